// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte port between
// NUM_REQ byte streams. The winner owns the port for a whole packet (up to
// req_last). An idle-cycle timeout releases an owner that stalls mid-packet.

// Per-requester steering. This is pure gating, so the req->tx and
// tx_ready->req_ready paths stay mux-only.
module uart_tx_arbiter_lane (
    input  logic       i_sel,
    input  logic       i_locked,
    input  logic       i_valid,
    input  logic       i_last,
    input  logic [7:0] i_data,
    input  logic       i_tx_ready,
    output logic       o_grant,
    output logic       o_ready,
    output logic       o_valid,
    output logic       o_last,
    output logic [7:0] o_data
);
    assign o_grant = i_sel & i_locked;
    assign o_ready = o_grant & i_tx_ready;
    assign o_valid = o_grant & i_valid;
    assign o_last  = o_grant & i_last;
    assign o_data  = i_data & {8{o_grant}};
endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_pulse
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (LOCK_TIMEOUT > 0);
    // The counter value one cycle before the limit. When it is seen with no
    // transfer, the next edge is the timeout edge.
    localparam logic [CW-1:0] TO_LIM  = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = (LOCK_TIMEOUT > 0) ? CW'(LOCK_TIMEOUT) : {CW{1'b1}};

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_g;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_to;

    logic                      w_locked;
    logic [NUM_REQ-1:0]        w_lane_vld;
    logic [NUM_REQ-1:0]        w_lane_last;
    logic [NUM_REQ-1:0][7:0]   w_lane_data;
    logic [7:0]                w_data;
    logic                      w_last;
    logic                      w_xfer;
    logic                      w_to;
    logic [IW-1:0]             w_win;
    logic                      w_found;

    assign w_locked = (r_state == S_LOCKED);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        uart_tx_arbiter_lane u_lane (
            .i_sel      (r_g == IW'(gi)),
            .i_locked   (w_locked),
            .i_valid    (req_valid[gi]),
            .i_last     (req_last[gi]),
            .i_data     (req_data[8*gi +: 8]),
            .i_tx_ready (tx_ready),
            .o_grant    (grant[gi]),
            .o_ready    (req_ready[gi]),
            .o_valid    (w_lane_vld[gi]),
            .o_last     (w_lane_last[gi]),
            .o_data     (w_lane_data[gi])
        );
    end

    // Only the owner's lane is non-zero, so OR-ing the lanes selects its byte.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_data = w_data | w_lane_data[i];
        end
    end

    assign tx_data       = w_data;
    assign tx_valid      = |w_lane_vld;
    assign w_last        = |w_lane_last;
    assign w_xfer        = tx_valid & tx_ready;
    assign w_to          = TO_EN && w_locked && !w_xfer && (r_cnt == TO_LIM);
    assign busy          = w_locked;
    assign timeout_pulse = r_to;

    // Round-robin search. Start just after the last winner, wrapping at NUM_REQ.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Lock/release FSM and the idle counter. A transfer on the limit cycle
    // clears the counter before the timeout can fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_ptr   <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_to <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_state <= S_LOCKED;
                        r_g     <= w_win;
                        r_ptr   <= w_win;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_cnt <= '0;
                        if (w_last) r_state <= S_IDLE;
                    end else begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                        if (w_to) begin
                            r_state <= S_IDLE;
                            r_to    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
